// File: rtl/picorv32_core.sv
// picorv32_core
// Minimal multi-cycle RV32I core with one shared valid/ready memory port.
// Each instruction is fetched, executed in one EXEC cycle, and loads/stores
// then run one data transaction. The core halts in TRAP on EBREAK/ECALL,
// illegal encodings or misaligned accesses.
//
// Ports:
//   clk        - clock, all state changes on the rising edge
//   resetn     - synchronous active-low reset
//   trap       - sticky halt indicator
//   mem_valid  - transaction request
//   mem_instr  - current transaction is an instruction fetch
//   mem_ready  - memory completion strobe
//   mem_addr   - word address (bits [1:0] always zero)
//   mem_wdata  - store data placed on its byte lanes
//   mem_wstrb  - byte write enables, 0000 for reads
//   mem_rdata  - read data, valid with mem_ready
module picorv32_core #(
  parameter logic [31:0] PROGADDR_RESET = 32'h0000_0000,
  parameter bit          CATCH_MISALIGN = 1'b1,
  parameter bit          CATCH_ILLINSN  = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        trap,
  output logic        mem_valid,
  output logic        mem_instr,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_TRAP} state_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  state_t      state, state_next;
  logic [31:0] pc, insn;
  logic [31:0] regs [0:31];
  logic [4:0]  ld_rd;
  logic [2:0]  ld_f3;
  logic [1:0]  ld_off;

  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val, pc_plus4;

  logic [31:0] alu_b, alu_out, wb_val, target, ls_addr;
  logic        alu_sub, br_cond, wb_en, jump;
  logic        is_load, is_store, illegal, sys_trap, misalign, exec_trap;
  logic [31:0] st_wdata, load_val;
  logic [3:0]  st_wstrb;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  assign opcode   = insn[6:0];
  assign rd       = insn[11:7];
  assign funct3   = insn[14:12];
  assign rs1      = insn[19:15];
  assign rs2      = insn[24:20];
  assign funct7   = insn[31:25];
  assign imm_i    = {{20{insn[31]}}, insn[31:20]};
  assign imm_s    = {{20{insn[31]}}, insn[31:25], insn[11:7]};
  assign imm_b    = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
  assign imm_u    = {insn[31:12], 12'd0};
  assign imm_j    = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
  assign rs1_val  = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
  assign rs2_val  = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
  assign pc_plus4 = pc + 32'd4;

  // ALU shared by OP and OP-IMM; SUB only exists in the register form
  always_comb begin
    alu_b   = (opcode == OPC_OP) ? rs2_val : imm_i;
    alu_sub = (opcode == OPC_OP) && funct7[5];
    alu_out = 32'd0;
    case (funct3)
      3'b000:  alu_out = alu_sub ? rs1_val - alu_b : rs1_val + alu_b;
      3'b001:  alu_out = rs1_val << alu_b[4:0];
      3'b010:  alu_out = {31'd0, $signed(rs1_val) < $signed(alu_b)};
      3'b011:  alu_out = {31'd0, rs1_val < alu_b};
      3'b100:  alu_out = rs1_val ^ alu_b;
      3'b101:  alu_out = funct7[5] ? $unsigned($signed(rs1_val) >>> alu_b[4:0])
                                   : rs1_val >> alu_b[4:0];
      3'b110:  alu_out = rs1_val | alu_b;
      default: alu_out = rs1_val & alu_b;
    endcase
  end

  always_comb begin
    br_cond = 1'b0;
    case (funct3)
      3'b000:  br_cond = rs1_val == rs2_val;
      3'b001:  br_cond = rs1_val != rs2_val;
      3'b100:  br_cond = $signed(rs1_val) < $signed(rs2_val);
      3'b101:  br_cond = !($signed(rs1_val) < $signed(rs2_val));
      3'b110:  br_cond = rs1_val < rs2_val;
      3'b111:  br_cond = !(rs1_val < rs2_val);
      default: br_cond = 1'b0;
    endcase
  end

  // Instruction decode: write-back, control flow, memory intent and legality
  always_comb begin
    wb_en    = 1'b0;
    wb_val   = alu_out;
    jump     = 1'b0;
    target   = pc_plus4;
    is_load  = 1'b0;
    is_store = 1'b0;
    illegal  = 1'b0;
    sys_trap = 1'b0;
    misalign = 1'b0;
    ls_addr  = rs1_val + ((opcode == OPC_STORE) ? imm_s : imm_i);
    case (opcode)
      OPC_LUI: begin
        wb_en  = 1'b1;
        wb_val = imm_u;
      end
      OPC_AUIPC: begin
        wb_en  = 1'b1;
        wb_val = pc + imm_u;
      end
      OPC_JAL: begin
        wb_en  = 1'b1;
        wb_val = pc_plus4;
        jump   = 1'b1;
        target = pc + imm_j;
      end
      OPC_JALR: begin
        if (funct3 != 3'b000) begin
          illegal = 1'b1;
        end else begin
          wb_en  = 1'b1;
          wb_val = pc_plus4;
          jump   = 1'b1;
          target = (rs1_val + imm_i) & ~32'd1;
        end
      end
      OPC_BRANCH: begin
        if (funct3 == 3'b010 || funct3 == 3'b011) begin
          illegal = 1'b1;
        end else if (br_cond) begin
          jump   = 1'b1;
          target = pc + imm_b;
        end
      end
      OPC_LOAD: begin
        if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) begin
          illegal = 1'b1;
        end else begin
          is_load  = 1'b1;
          misalign = (funct3[1:0] == 2'b10 && ls_addr[1:0] != 2'b00) ||
                     (funct3[1:0] == 2'b01 && ls_addr[0]);
        end
      end
      OPC_STORE: begin
        if (funct3[2] || funct3 == 3'b011) begin
          illegal = 1'b1;
        end else begin
          is_store = 1'b1;
          misalign = (funct3[1:0] == 2'b10 && ls_addr[1:0] != 2'b00) ||
                     (funct3[1:0] == 2'b01 && ls_addr[0]);
        end
      end
      OPC_OPIMM: begin
        if ((funct3 == 3'b001 && funct7 != 7'b0000000) ||
            (funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000))
          illegal = 1'b1;
        else
          wb_en = 1'b1;
      end
      OPC_OP: begin
        if (funct7 == 7'b0000000 ||
            (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)))
          wb_en = 1'b1;
        else
          illegal = 1'b1;
      end
      OPC_FENCE: begin
        if (funct3 != 3'b000) illegal = 1'b1;
      end
      OPC_SYSTEM: begin
        // ECALL/EBREAK always halt; anything else here (CSR) is unsupported
        if (insn == 32'h0000_0073 || insn == 32'h0010_0073)
          sys_trap = 1'b1;
        else
          illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
    if (jump && target[1:0] != 2'b00) misalign = 1'b1;
    exec_trap = sys_trap || (CATCH_ILLINSN && illegal) || (CATCH_MISALIGN && misalign);
  end

  // Store data is replicated on every lane so the strobe alone selects bytes
  always_comb begin
    st_wdata = rs2_val;
    st_wstrb = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        st_wdata = {4{rs2_val[7:0]}};
        st_wstrb = 4'b0001 << ls_addr[1:0];
      end
      2'b01: begin
        st_wdata = {2{rs2_val[15:0]}};
        st_wstrb = ls_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_wdata = rs2_val;
        st_wstrb = 4'b1111;
      end
    endcase
  end

  always_comb begin
    ld_half  = ld_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ld_byte  = mem_rdata[7:0];
    load_val = mem_rdata;
    case (ld_off)
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    case (ld_f3)
      3'b000:  load_val = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_val = {{16{ld_half[15]}}, ld_half};
      3'b100:  load_val = {24'd0, ld_byte};
      3'b101:  load_val = {16'd0, ld_half};
      default: load_val = mem_rdata;
    endcase
  end

  // Register file write port: EXEC results or load data returning in MEM
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = rd;
    rf_wdata = wb_val;
    if (state == S_EXEC) begin
      rf_we = !exec_trap && wb_en;
    end else if (state == S_MEM) begin
      rf_waddr = ld_rd;
      rf_wdata = load_val;
      rf_we    = mem_ready && (mem_wstrb == 4'b0000);
    end
    if (!resetn || rf_waddr == 5'd0) rf_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rf_we) regs[rf_waddr] <= rf_wdata;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH: if (mem_valid && mem_ready) state_next = S_EXEC;
      S_EXEC: begin
        if (exec_trap)               state_next = S_TRAP;
        else if (is_load || is_store) state_next = S_MEM;
        else                          state_next = S_FETCH;
      end
      S_MEM:   if (mem_ready) state_next = S_FETCH;
      default: state_next = S_TRAP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) state <= S_FETCH;
    else         state <= state_next;
  end

  // Bus and PC registers; a request is raised one cycle after the previous
  // one completes, so mem_valid always has a low cycle between transactions
  always_ff @(posedge clk) begin
    if (!resetn) begin
      trap      <= 1'b0;
      mem_valid <= 1'b0;
      mem_instr <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_wstrb <= 4'd0;
      pc        <= PROGADDR_RESET;
      insn      <= 32'd0;
      ld_rd     <= 5'd0;
      ld_f3     <= 3'd0;
      ld_off    <= 2'd0;
    end else begin
      case (state)
        S_FETCH: begin
          if (!mem_valid) begin
            mem_valid <= 1'b1;
            mem_instr <= 1'b1;
            mem_addr  <= {pc[31:2], 2'b00};
            mem_wstrb <= 4'd0;
          end else if (mem_ready) begin
            mem_valid <= 1'b0;
            insn      <= mem_rdata;
          end
        end
        S_EXEC: begin
          if (exec_trap) begin
            trap <= 1'b1;
          end else begin
            pc <= {target[31:2], 2'b00};
            if (is_load || is_store) begin
              mem_valid <= 1'b1;
              mem_instr <= 1'b0;
              mem_addr  <= {ls_addr[31:2], 2'b00};
              mem_wdata <= is_store ? st_wdata : 32'd0;
              mem_wstrb <= is_store ? st_wstrb : 4'd0;
              ld_rd     <= rd;
              ld_f3     <= funct3;
              ld_off    <= ls_addr[1:0];
            end
          end
        end
        S_MEM: begin
          if (mem_ready) mem_valid <= 1'b0;
        end
        default: mem_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_picorv32_core.sv
// tb_picorv32_core
// Directed programs run against a behavioural memory. Expected data
// transactions are queued before each program starts and compared as the
// core issues them; control-flow and trap behaviour is checked by counts.
module tb_picorv32_core;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic        clk;
  logic        resetn;
  logic        trap;
  logic        mem_valid;
  logic        mem_instr;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:255];
  logic [67:0] exp_q[$];
  int total, bad;
  int fetch_cnt, data_cnt, watch_hits, stable_err, fetch_delay;
  logic [31:0] watch_addr;

  picorv32_core dut (
    .clk       (clk),
    .resetn    (resetn),
    .trap      (trap),
    .mem_valid (mem_valid),
    .mem_instr (mem_instr),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  // One comparison: counts it and reports a mismatch through $error
  task automatic checkOutput(input string tag, input logic [71:0] observed,
                             input logic [71:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic expect_txn(input logic [31:0] addr, input logic [3:0] wstrb,
                            input logic [31:0] wdata);
    exp_q.push_back({addr, wstrb, wdata});
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = EBREAK;
    for (int i = 64; i < 256; i++) mem[i] = 32'd0;
    exp_q.delete();
  endtask

  // Memory responder: answers after fetch_delay waiting cycles on fetches,
  // immediately on data accesses, and checks request stability while waiting
  initial begin
    logic [68:0] cur, lat;
    logic [67:0] e;
    logic [7:0]  widx;
    int wait_cnt;
    logic in_txn;
    mem_ready = 1'b0;
    mem_rdata = 32'd0;
    in_txn    = 1'b0;
    wait_cnt  = 0;
    lat       = '0;
    forever begin
      @(negedge clk);
      if (resetn !== 1'b1) begin
        mem_ready = 1'b0;
        in_txn    = 1'b0;
        wait_cnt  = 0;
      end else if (mem_ready) begin
        mem_ready = 1'b0;
        in_txn    = 1'b0;
      end else if (mem_valid === 1'b1) begin
        cur = {mem_instr, mem_wstrb, mem_addr, mem_wdata};
        if (!in_txn) begin
          in_txn   = 1'b1;
          lat      = cur;
          wait_cnt = 0;
        end else if (cur !== lat) begin
          stable_err++;
        end
        if (wait_cnt >= (mem_instr ? fetch_delay : 0)) begin
          widx      = mem_addr[9:2];
          mem_rdata = mem[widx];
          for (int b = 0; b < 4; b++)
            if (mem_wstrb[b]) mem[widx][8*b +: 8] = mem_wdata[8*b +: 8];
          if (mem_instr) begin
            fetch_cnt++;
            if (mem_addr == watch_addr) watch_hits++;
          end else begin
            data_cnt++;
            checkOutput("sb_pending", 72'(exp_q.size() != 0), 72'd1);
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              checkOutput("data_txn",
                          72'({mem_addr, mem_wstrb, (mem_wstrb != 4'd0) ? mem_wdata : 32'd0}),
                          72'(e));
            end
          end
          mem_ready = 1'b1;
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  // Reset for `hold` cycles, release, check the first fetch, run to trap
  task automatic applyStimulus(input int hold, input int delay);
    int rst_bad, cyc, idle_bad;
    @(posedge clk);
    #1 resetn = 1'b0;
    fetch_delay = delay;
    rst_bad = 0;
    repeat (hold) begin
      @(posedge clk);
      #1;
      if (trap !== 1'b0 || mem_valid !== 1'b0) rst_bad++;
    end
    checkOutput("reset_quiet", 72'(rst_bad), 72'd0);
    checkOutput("reset_outputs", 72'({trap, mem_valid, mem_instr, mem_wstrb}), 72'd0);
    fetch_cnt  = 0;
    data_cnt   = 0;
    watch_hits = 0;
    stable_err = 0;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("first_fetch", 72'({trap, mem_valid, mem_instr, mem_addr}),
                72'({1'b0, 1'b1, 1'b1, 32'h0}));
    cyc = 0;
    while (trap !== 1'b1 && cyc < 3000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checkOutput("trap", 72'(trap), 72'd1);
    idle_bad = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (mem_valid !== 1'b0 || trap !== 1'b1) idle_bad++;
    end
    checkOutput("halted_idle", 72'(idle_bad), 72'd0);
    checkOutput("sb_drained", 72'(exp_q.size()), 72'd0);
  endtask

  task automatic load_basic();
    clear_mem();
    mem[0] = enc_i(12'd5, 5'd0, 3'b000, 5'd1, OP_IMM);
    mem[1] = enc_s(12'h100, 5'd1, 5'd0, 3'b010);
    mem[2] = enc_i(12'h100, 5'd0, 3'b010, 5'd2, OP_LD);
    mem[3] = enc_s(12'h104, 5'd2, 5'd0, 3'b010);
    mem[4] = EBREAK;
    expect_txn(32'h100, 4'b1111, 32'd5);
    expect_txn(32'h100, 4'b0000, 32'd0);
    expect_txn(32'h104, 4'b1111, 32'd5);
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    resetn      = 1'b0;
    fetch_delay = 0;
    watch_addr  = 32'hFFFF_FFFF;

    // Word store / load round trip, with a long initial reset hold
    load_basic();
    applyStimulus(20, 0);
    checkOutput("basic_fetches", 72'(fetch_cnt), 72'd5);

    // Byte and halfword stores, signed and unsigned sub-word loads
    clear_mem();
    mem[0]  = enc_i(12'h0A5, 5'd0, 3'b000, 5'd1, OP_IMM);
    mem[1]  = enc_s(12'h101, 5'd1, 5'd0, 3'b000);
    mem[2]  = enc_i(12'h101, 5'd0, 3'b000, 5'd4, OP_LD);
    mem[3]  = enc_s(12'h108, 5'd4, 5'd0, 3'b010);
    mem[4]  = enc_i(12'h101, 5'd0, 3'b100, 5'd7, OP_LD);
    mem[5]  = enc_s(12'h10C, 5'd7, 5'd0, 3'b010);
    mem[6]  = enc_i(12'hFFE, 5'd0, 3'b000, 5'd5, OP_IMM);
    mem[7]  = enc_s(12'h112, 5'd5, 5'd0, 3'b001);
    mem[8]  = enc_i(12'h112, 5'd0, 3'b101, 5'd6, OP_LD);
    mem[9]  = enc_i(12'h112, 5'd0, 3'b001, 5'd8, OP_LD);
    mem[10] = enc_s(12'h114, 5'd6, 5'd0, 3'b010);
    mem[11] = enc_s(12'h118, 5'd8, 5'd0, 3'b010);
    mem[12] = EBREAK;
    expect_txn(32'h100, 4'b0010, 32'hA5A5_A5A5);
    expect_txn(32'h100, 4'b0000, 32'd0);
    expect_txn(32'h108, 4'b1111, 32'hFFFF_FFA5);
    expect_txn(32'h100, 4'b0000, 32'd0);
    expect_txn(32'h10C, 4'b1111, 32'h0000_00A5);
    expect_txn(32'h110, 4'b1100, 32'hFFFE_FFFE);
    expect_txn(32'h110, 4'b0000, 32'd0);
    expect_txn(32'h110, 4'b0000, 32'd0);
    expect_txn(32'h114, 4'b1111, 32'h0000_FFFE);
    expect_txn(32'h118, 4'b1111, 32'hFFFF_FFFE);
    applyStimulus(3, 0);

    // Register ALU ops, shifts, compares, LUI and JAL link value
    clear_mem();
    mem[0]  = enc_i(12'h0A5, 5'd0, 3'b000, 5'd1, OP_IMM);
    mem[1]  = enc_r(7'b0100000, 5'd1, 5'd0, 3'b000, 5'd8);
    mem[2]  = enc_i(12'h404, 5'd8, 3'b101, 5'd9, OP_IMM);
    mem[3]  = enc_r(7'b0000000, 5'd8, 5'd1, 3'b011, 5'd10);
    mem[4]  = enc_r(7'b0000000, 5'd8, 5'd1, 3'b010, 5'd11);
    mem[5]  = {20'h12345, 5'd12, 7'b0110111};
    mem[6]  = enc_s(12'h100, 5'd8, 5'd0, 3'b010);
    mem[7]  = enc_s(12'h104, 5'd9, 5'd0, 3'b010);
    mem[8]  = enc_s(12'h108, 5'd10, 5'd0, 3'b010);
    mem[9]  = enc_s(12'h10C, 5'd11, 5'd0, 3'b010);
    mem[10] = enc_s(12'h110, 5'd12, 5'd0, 3'b010);
    mem[11] = enc_j(21'd8, 5'd13);
    mem[12] = EBREAK;
    mem[13] = enc_s(12'h114, 5'd13, 5'd0, 3'b010);
    mem[14] = EBREAK;
    expect_txn(32'h100, 4'b1111, 32'hFFFF_FF5B);
    expect_txn(32'h104, 4'b1111, 32'hFFFF_FFF5);
    expect_txn(32'h108, 4'b1111, 32'd1);
    expect_txn(32'h10C, 4'b1111, 32'd0);
    expect_txn(32'h110, 4'b1111, 32'h1234_5000);
    expect_txn(32'h114, 4'b1111, 32'h0000_0030);
    applyStimulus(3, 0);

    // BNE loop entered at the test: x3 counts 3 -> 0, body runs 3 times
    clear_mem();
    mem[0] = enc_i(12'd0, 5'd0, 3'b000, 5'd4, OP_IMM);
    mem[1] = enc_i(12'd3, 5'd0, 3'b000, 5'd3, OP_IMM);
    mem[2] = enc_j(21'd12, 5'd0);
    mem[3] = enc_i(12'hFFF, 5'd3, 3'b000, 5'd3, OP_IMM);
    mem[4] = enc_i(12'd1, 5'd4, 3'b000, 5'd4, OP_IMM);
    mem[5] = enc_b(13'h1FF8, 5'd0, 5'd3, 3'b001);
    mem[6] = enc_s(12'h100, 5'd4, 5'd0, 3'b010);
    mem[7] = enc_s(12'h104, 5'd3, 5'd0, 3'b010);
    mem[8] = EBREAK;
    expect_txn(32'h100, 4'b1111, 32'd3);
    expect_txn(32'h104, 4'b1111, 32'd0);
    watch_addr = 32'h0000_000C;
    applyStimulus(3, 0);
    checkOutput("loop_branch_backs", 72'(watch_hits), 72'd3);
    watch_addr = 32'hFFFF_FFFF;

    // All-zero word is illegal: halt after one fetch, no data access
    clear_mem();
    mem[0] = 32'h0000_0000;
    mem[1] = enc_s(12'h100, 5'd0, 5'd0, 3'b010);
    applyStimulus(3, 0);
    checkOutput("illegal_fetches", 72'(fetch_cnt), 72'd1);
    checkOutput("illegal_no_data", 72'(data_cnt), 72'd0);

    // LW from 0x102 is misaligned: halt with no data transaction
    clear_mem();
    mem[0] = enc_i(12'd2, 5'd0, 3'b000, 5'd1, OP_IMM);
    mem[1] = enc_i(12'h100, 5'd1, 3'b010, 5'd2, OP_LD);
    mem[2] = enc_s(12'h100, 5'd0, 5'd0, 3'b010);
    applyStimulus(3, 0);
    checkOutput("misalign_fetches", 72'(fetch_cnt), 72'd2);
    checkOutput("misalign_no_data", 72'(data_cnt), 72'd0);

    // Every fetch held off for 10 cycles: request must stay stable
    load_basic();
    applyStimulus(3, 10);
    checkOutput("slow_stable", 72'(stable_err), 72'd0);
    checkOutput("slow_fetches", 72'(fetch_cnt), 72'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
